// File: rtl/phase_selector_gen_if.sv
// Phase selector handshake bundle.
// Timer controls in, one-hot select and status out.
interface phase_selector_gen_if #(
  parameter int CNT_WIDTH = 8
);
  logic                 enable;
  logic [CNT_WIDTH-1:0] dwell3;
  logic [CNT_WIDTH-1:0] dwell2;
  logic [CNT_WIDTH-1:0] dwell1;
  logic [CNT_WIDTH-1:0] dwell0;
  logic [3:0]           skip;
  logic                 force_valid;
  logic [1:0]           force_sel;
  logic [3:0]           selector;
  logic [1:0]           phase_idx;
  logic [CNT_WIDTH-1:0] remaining;
  logic                 phase_done;

  modport master (
    output enable, dwell3, dwell2, dwell1, dwell0,
    output skip, force_valid, force_sel,
    input  selector, phase_idx, remaining, phase_done
  );

  modport slave (
    input  enable, dwell3, dwell2, dwell1, dwell0,
    input  skip, force_valid, force_sel,
    output selector, phase_idx, remaining, phase_done
  );
endinterface

// File: rtl/phase_selector_gen.sv
// Four-phase dwell timer driving a one-hot mux select.
// Ring advance with skip mask, forced jumps, freeze.
module phase_selector_gen #(
  parameter int CNT_WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  phase_selector_gen_if.slave bus
);
  typedef enum logic [1:0] {
    S_LOAD,
    S_RUN,
    S_HOLD
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           idx_q, idx_d;
  logic [CNT_WIDTH-1:0] rem_q, rem_d;
  logic                 done_q, done_d;
  logic [1:0]           nxt_idx;
  logic [1:0]           step1, step2, step3;
  logic [CNT_WIDTH-1:0] dwell [4];

  assign dwell[0] = bus.dwell0;
  assign dwell[1] = bus.dwell1;
  assign dwell[2] = bus.dwell2;
  assign dwell[3] = bus.dwell3;

  assign step1 = idx_q + 2'd1;
  assign step2 = idx_q + 2'd2;
  assign step3 = idx_q + 2'd3;

  // Nearest non-skipped phase in ring order; stay put if none.
  always_comb begin
    nxt_idx = idx_q;
    priority case (1'b1)
      !bus.skip[step1]: nxt_idx = step1;
      !bus.skip[step2]: nxt_idx = step2;
      !bus.skip[step3]: nxt_idx = step3;
      default:          nxt_idx = idx_q;
    endcase
  end

  // Next state: force first, then load/run/hold behaviour.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    if (bus.force_valid) begin
      idx_d   = bus.force_sel;
      rem_d   = dwell[bus.force_sel];
      done_d  = 1'b1;
      state_d = bus.enable ? S_RUN : S_HOLD;
    end else begin
      unique case (state_q)
        S_LOAD: begin
          if (bus.enable) begin
            rem_d   = dwell[idx_q];
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          if (!bus.enable) begin
            state_d = S_HOLD;
          end else if (rem_q != '0) begin
            rem_d = rem_q - CNT_WIDTH'(1);
          end else begin
            idx_d  = nxt_idx;
            rem_d  = dwell[nxt_idx];
            done_d = 1'b1;
          end
        end
        S_HOLD: begin
          if (bus.enable) state_d = S_RUN;
        end
        default: state_d = S_LOAD;
      endcase
    end
  end

  // State registers with asynchronous reset to phase 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_LOAD;
      idx_q   <= 2'd0;
      rem_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
    end
  end

  assign bus.selector   = 4'b0001 << idx_q;
  assign bus.phase_idx  = idx_q;
  assign bus.remaining  = rem_q;
  assign bus.phase_done = done_q;
endmodule

// File: doc/phase_selector_gen.md
PHASE_SELECTOR_GEN -- requirements
Module: phase_selector_gen

Interface
REQ-001 Parameter CNT_WIDTH, default 8, width of the dwell counters and the remaining-count output.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 enable  input  1  high = the phase timer runs; low = the timer freezes.
REQ-005 dwell3, dwell2, dwell1, dwell0  input  CNT_WIDTH each  per-phase dwell count; phase k lasts dwellk+1 enabled cycles.
REQ-006 skip  input  4  bit k high = phase k is excluded from natural advance.
REQ-007 force_valid  input  1  one-cycle request to jump to force_sel.
REQ-008 force_sel  input  2  binary index of the forced phase.
REQ-009 selector  output  4  one-hot active phase; drives the select input of a Mux4 one-hot multiplexer.
REQ-010 phase_idx  output  2  binary index of the active phase; always consistent with selector.
REQ-011 remaining  output  CNT_WIDTH  enabled cycles left in the current phase.
REQ-012 phase_done  output  1  registered one-cycle pulse on every phase change.

Function
REQ-013 The block SHALL implement the states S_LOAD, S_RUN and S_HOLD.
REQ-014 selector SHALL be exactly one-hot in every cycle, including during and after reset.
REQ-015 In S_LOAD with enable=1, the block SHALL load remaining with dwell[phase_idx] and go to S_RUN; with enable=0 it SHALL stay in S_LOAD.
REQ-016 In S_RUN with enable=1 and remaining>0, the block SHALL decrement remaining by 1.
REQ-017 In S_RUN with enable=1 and remaining==0, the block SHALL advance to the next phase in ring order 0->1->2->3->0 whose skip bit is 0.
REQ-018 On an advance, the block SHALL load remaining with the new phase's dwell value and pulse phase_done for one cycle.
REQ-019 If every phase other than the current one is skipped, the block SHALL stay on the current phase, reload its dwell value, and still pulse phase_done.
REQ-020 The skip bit of the current phase SHALL have no effect on the current phase; it matters only when the ring search reaches that phase.
REQ-021 If all four skip bits are set, the block SHALL stay on the current phase and reload it, as in REQ-019.
REQ-022 In S_RUN with enable=0, the block SHALL go to S_HOLD with remaining unchanged.
REQ-023 In S_HOLD with enable=1, the block SHALL return to S_RUN without reloading remaining; decrementing resumes on the next enabled cycle.
REQ-024 force_valid=1 in any state SHALL, on that edge:
  - set selector to onehot(force_sel);
  - load remaining with dwell[force_sel];
  - pulse phase_done;
  - enter S_RUN if enable=1, else S_HOLD.
REQ-025 Force SHALL ignore skip.
REQ-026 Force SHALL take priority over a natural expiry in the same cycle.
REQ-027 A force to the phase that is already active SHALL reload its dwell value and pulse phase_done.
REQ-028 Dwell inputs SHALL be sampled only at load, advance or force; changes at any other time SHALL not affect the running count.
REQ-029 dwell=0 SHALL give a phase one enabled cycle; dwell=2^CNT_WIDTH-1 SHALL give 2^CNT_WIDTH enabled cycles, with no wrap of remaining.
REQ-030 phase_done SHALL be 0 in every cycle without an advance or force.

Reset
REQ-031 While rst=1, outputs SHALL be: selector=4'b0001, phase_idx=0, remaining=0, phase_done=0, state=S_LOAD.
REQ-032 Reset asserted mid-phase SHALL take effect immediately and asynchronously, with no phase_done pulse.
REQ-033 After release, the first enabled edge SHALL load dwell0 (REQ-015).

Verification
REQ-034 Nominal ring: CNT_WIDTH=8, dwell0..3=2,1,0,3, skip=0, enable=1 after reset.
  - Response: selector 0001 (3 cycles after load), 0010 (2), 0100 (1), 1000 (4), then 0001.
  - phase_done pulses exactly at each change.
REQ-035 Skip: skip=4'b0110 while on phase 0 with dwell0=1.
  - Response: phase_idx goes 0->3->0.
  - Change only after reaching 3: skip=4'b1110 -> stays on phase 0, which reloads and pulses phase_done each expiry.
REQ-036 Freeze: enable low for 5 cycles while remaining=2.
  - Response: remaining holds at 2 and selector holds.
  - After re-enable: 2, 1, 0, then advance.
REQ-037 Force versus expiry: force_valid=1, force_sel=2 in the same cycle phase 1 reaches remaining==0 with dwell2=4.
  - Response: selector=0100, remaining=4, exactly one phase_done pulse.
REQ-038 Reset mid-operation: rst pulsed asynchronously while phase 3 runs with remaining=5.
  - Response: immediate selector=0001, remaining=0, phase_done=0.
  - First enabled edge after release loads dwell0.
REQ-039 Boundary: dwell0=255, enable=1.
  - Response: phase 0 lasts exactly 256 enabled cycles; remaining never wraps.
  - Assertion over the whole run: selector one-hot and consistent with phase_idx every cycle.
